// File: rtl/fifo_burst_drain_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO burst drain arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER
  } state_e;

  // A burst length field of zero encodes the largest burst, 2**bits words.
  function automatic int unsigned burst_words(input int unsigned len, input int unsigned bits);
    return (len == 0) ? (32'd1 << bits) : len;
  endfunction

endpackage

// File: rtl/fifo_burst_drain_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr_i, wrapping at NCH-1.
module fifo_rr_pick #(
  parameter int NCH      = 4,
  parameter int CHN_BITS = 2
) (
  input  logic [NCH-1:0]      req_i,
  input  logic [CHN_BITS-1:0] ptr_i,
  output logic                valid_o,
  output logic [CHN_BITS-1:0] idx_o
);

  localparam int SW = CHN_BITS + 1;

  logic [2*NCH-1:0]    dbl_w;
  logic [2*NCH-1:0]    shr_w;
  logic [CHN_BITS-1:0] off_w;
  logic [SW-1:0]       sum_w;

  // Shifting a doubled copy rotates the requests so bit 0 is the pointer's channel.
  assign dbl_w = {req_i, req_i};
  assign shr_w = dbl_w >> ptr_i;

  always_comb begin
    off_w = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (shr_w[k]) begin
        off_w = CHN_BITS'(k);
      end
    end
  end

  assign sum_w   = {1'b0, ptr_i} + {1'b0, off_w};
  assign idx_o   = (sum_w >= SW'(NCH)) ? CHN_BITS'(sum_w - SW'(NCH)) : CHN_BITS'(sum_w);
  assign valid_o = |req_i;

endmodule

// File: rtl/fifo_burst_drain_arbiter.sv
// Round-robin read scheduler draining bursts from NCH same-clock FIFOs into one tagged stream.
module fifo_burst_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CHN_BITS   = 2,
  parameter int WIDTH      = 9,
  parameter int BURST_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic [BURST_BITS-1:0]      burst_len_i,
  input  logic [NCH*(WIDTH+1)-1:0]   fill_in_i,
  input  logic [NCH-1:0]             nempty_i,
  input  logic                       dst_ready_i,
  output logic [NCH-1:0]             rd_o,
  output logic                       out_we_o,
  output logic [CHN_BITS-1:0]        out_chn_o,
  output logic                       out_first_o,
  output logic                       out_last_o,
  output logic                       busy_o
);

  localparam int FW = WIDTH + 1;
  localparam int LW = BURST_BITS + 1;

  state_e              state_q;
  logic [CHN_BITS-1:0] chn_q;
  logic [CHN_BITS-1:0] rr_q;
  logic [CHN_BITS-1:0] rr_d;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       len_d;
  logic [LW-1:0]       cnt_q;
  logic                busy_q;

  logic [LW-1:0]       l_words;
  logic [FW-1:0]       l_ext;
  logic [FW-1:0]       fill_w [NCH];
  logic [NCH-1:0]      elig;
  logic                pick_valid;
  logic [CHN_BITS-1:0] pick_idx;
  logic [FW-1:0]       fill_sel;
  logic                xfer_rd;
  logic                last_w;

  assign l_words = LW'(burst_words(32'(burst_len_i), BURST_BITS));
  assign l_ext   = FW'(l_words);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
    assign fill_w[gi] = fill_in_i[gi*FW +: FW];
    assign elig[gi]   = (fill_w[gi] >= l_ext) |
                        (flush_i & (nempty_i[gi] | (fill_w[gi] != '0)));
  end

  fifo_rr_pick #(
    .NCH      (NCH),
    .CHN_BITS (CHN_BITS)
  ) u_pick (
    .req_i   (elig),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Fill only grows while we hold the grant, so any length up to fill is safe to commit to.
  assign fill_sel = fill_w[chn_q];
  always_comb begin
    if (fill_sel == '0) begin
      len_d = LW'(1);
    end else if (fill_sel < l_ext) begin
      len_d = LW'(fill_sel);
    end else begin
      len_d = l_words;
    end
  end

  assign rr_d = (chn_q == CHN_BITS'(NCH - 1)) ? '0 : chn_q + CHN_BITS'(1);

  assign xfer_rd = (state_q == XFER) & dst_ready_i & nempty_i[chn_q];
  assign last_w  = (cnt_q == len_q - LW'(1));

  always_comb begin
    rd_o        = '0;
    rd_o[chn_q] = xfer_rd;
  end

  assign out_we_o    = xfer_rd;
  assign out_first_o = xfer_rd & (cnt_q == '0);
  assign out_last_o  = xfer_rd & last_w;
  assign out_chn_o   = chn_q;
  assign busy_o      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chn_q   <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i && pick_valid) begin
            chn_q   <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          len_q   <= len_d;
          cnt_q   <= '0;
          rr_q    <= rr_d;
          state_q <= XFER;
        end
        XFER: begin
          if (xfer_rd) begin
            if (last_w) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + LW'(1);
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain_arbiter.sv
// Bench for fifo_burst_drain_arbiter: modelled FIFOs plus a burst-level reference scheduler.
module tb_fifo_burst_drain_arbiter;

  localparam int NCH        = 4;
  localparam int CHN_BITS   = 2;
  localparam int WIDTH      = 9;
  localparam int BURST_BITS = 4;
  localparam int FW         = WIDTH + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  flush = 1'b0;
  logic [BURST_BITS-1:0] burst_len = '0;
  logic [NCH*FW-1:0]     fill_in = '0;
  logic [NCH-1:0]        nempty = '0;
  logic                  dst_ready = 1'b0;
  logic [NCH-1:0]        rd_o;
  logic                  out_we_o;
  logic [CHN_BITS-1:0]   out_chn_o;
  logic                  out_first_o;
  logic                  out_last_o;
  logic                  busy_o;

  always #5 clk = ~clk;

  fifo_burst_drain_arbiter #(
    .NCH(NCH), .CHN_BITS(CHN_BITS), .WIDTH(WIDTH), .BURST_BITS(BURST_BITS)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .flush_i(flush), .burst_len_i(burst_len),
    .fill_in_i(fill_in), .nempty_i(nempty), .dst_ready_i(dst_ready),
    .rd_o(rd_o), .out_we_o(out_we_o), .out_chn_o(out_chn_o),
    .out_first_o(out_first_o), .out_last_o(out_last_o), .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus knobs and per-channel FIFO contents.
  int       cnt [NCH];
  bit       hid [NCH];
  bit [NCH-1:0] autofill = '0;
  bit [NCH-1:0] nblk = '0;
  bit       en_v = 0, flush_v = 0, dr_v = 1, dr_rand = 0, rst_v = 1;
  int       bl_v = 4;

  // Reference scheduler state.
  bit m_busy = 0, m_grant = 0, m_fin = 0;
  int m_chn = 0, m_len = 0, m_done = 0, m_rr = 0;
  bit p_rst = 1, p_en = 0, p_flush = 0;
  int p_bl = 4;
  int p_fill [NCH];
  bit p_ne [NCH];

  // Observed-stream logs.
  int grant_log[$];
  int words_log[$];
  int gap_log[$];
  int cur_words = 0, last_end_cyc = -1, burst_cnt = 0, fl_both = 0;
  bit p_busy_obs = 0;

  function automatic int lwords(int bl);
    return (bl == 0) ? (1 << BURST_BITS) : bl;
  endfunction

  function automatic int pick_prev();
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_rr + k) % NCH;
      if (p_fill[c] >= lwords(p_bl) || (p_flush && (p_ne[c] || p_fill[c] != 0)))
        return c;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    words_log.delete();
    gap_log.delete();
    cur_words = 0;
    last_end_cyc = -1;
    burst_cnt = 0;
    fl_both = 0;
  endtask

  // One clock cycle: drive inputs, predict, compare, update FIFO model.
  task automatic step();
    int fill_c [NCH];
    bit ne_c [NCH];
    bit exp_busy, exp_first, exp_last, bitv;
    logic [NCH-1:0] exp_rd;
    int pk, lw;
    @(negedge clk);
    cyc++;
    if (dr_rand) dr_v = 1'($urandom_range(0, 1));
    for (int c = 0; c < NCH; c++) begin
      if (autofill[c] && cnt[c] < 30) cnt[c] = 40;
      if (cnt[c] == 0) hid[c] = 0;
      fill_c[c] = cnt[c] - (hid[c] ? 1 : 0);
      ne_c[c] = (cnt[c] > 0) && !nblk[c];
      fill_in[c*FW +: FW] = FW'(fill_c[c]);
      nempty[c] = ne_c[c];
    end
    rst = rst_v;
    en = en_v;
    flush = flush_v;
    burst_len = BURST_BITS'(bl_v);
    dst_ready = dr_v;
    #1;
    exp_busy = 0;
    if (p_rst) begin
      m_busy = 0; m_grant = 0; m_fin = 0; m_rr = 0;
    end else if (!m_busy) begin
      pk = pick_prev();
      if (p_en && pk >= 0) begin
        exp_busy = 1; m_busy = 1; m_grant = 1; m_chn = pk; m_rr = (pk + 1) % NCH;
      end
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0;
    end else begin
      exp_busy = 1; m_grant = 0;
    end
    n_tests++;
    if (busy_o !== exp_busy) begin
      n_fail++;
      $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, exp_busy);
    end
    exp_rd = '0; exp_first = 0; exp_last = 0;
    if (m_busy && m_grant) begin
      lw = lwords(bl_v);
      m_len = (fill_c[m_chn] == 0) ? 1 : (fill_c[m_chn] < lw ? fill_c[m_chn] : lw);
      m_done = 0;
    end else if (m_busy) begin
      bitv = dr_v && ne_c[m_chn];
      if (bitv) begin
        exp_rd[m_chn] = 1'b1;
        exp_first = (m_done == 0);
        exp_last = (m_done == m_len - 1);
        m_done++;
        if (m_done == m_len) m_fin = 1;
        cnt[m_chn]--;
      end
    end
    if (m_busy) begin
      n_tests++;
      if (out_chn_o !== CHN_BITS'(m_chn)) begin
        n_fail++;
        $display("FAIL out_chn cyc=%0d got=%0d exp=%0d", cyc, out_chn_o, m_chn);
      end
    end
    n_tests++;
    if (rd_o !== exp_rd || out_we_o !== (|exp_rd) ||
        out_first_o !== exp_first || out_last_o !== exp_last) begin
      n_fail++;
      $display("FAIL rd_tags cyc=%0d got rd=%b we=%0b f=%0b l=%0b exp rd=%b f=%0b l=%0b",
               cyc, rd_o, out_we_o, out_first_o, out_last_o, exp_rd, exp_first, exp_last);
    end
    if (busy_o === 1'b1 && !p_busy_obs) grant_log.push_back(int'(out_chn_o));
    p_busy_obs = (busy_o === 1'b1);
    if (out_we_o === 1'b1) begin
      if (out_first_o === 1'b1) begin
        if (last_end_cyc >= 0) gap_log.push_back(cyc - last_end_cyc);
        cur_words = 0;
      end
      cur_words++;
      if (out_first_o === 1'b1 && out_last_o === 1'b1) fl_both++;
      if (out_last_o === 1'b1) begin
        words_log.push_back(cur_words);
        last_end_cyc = cyc;
        burst_cnt++;
      end
    end
    p_rst = rst_v; p_en = en_v; p_flush = flush_v; p_bl = bl_v;
    for (int c = 0; c < NCH; c++) begin
      p_fill[c] = fill_c[c];
      p_ne[c] = ne_c[c];
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_grants(int k, int lim, string nm);
    int i = 0;
    while (grant_log.size() < k && i < lim) begin step(); i++; end
    n_tests++;
    if (grant_log.size() < k) begin
      n_fail++;
      $display("FAIL %s_grant_timeout got=%0d grants exp=%0d", nm, grant_log.size(), k);
    end
  endtask

  task automatic wait_bursts(int k, int lim, string nm);
    int i = 0;
    while (burst_cnt < k && i < lim) begin step(); i++; end
    n_tests++;
    if (burst_cnt < k) begin
      n_fail++;
      $display("FAIL %s_burst_timeout got=%0d bursts exp=%0d", nm, burst_cnt, k);
    end
  endtask

  task automatic wait_words(int k, int lim);
    int i = 0;
    while (m_done < k && i < lim) begin step(); i++; end
  endtask

  task automatic quiesce();
    int i = 0;
    en_v = 0; dr_rand = 0; dr_v = 1; nblk = '0;
    while (m_busy && i < 300) begin step(); i++; end
    n_tests++;
    if (m_busy) begin
      n_fail++;
      $display("FAIL quiesce_timeout got=busy exp=idle");
    end
    autofill = '0; flush_v = 0;
    for (int c = 0; c < NCH; c++) begin cnt[c] = 0; hid[c] = 0; end
    run(2);
  endtask

  task automatic pulse_reset();
    rst_v = 1; run(2); rst_v = 0;
  endtask

  function automatic int qget(int q[$], int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic test_reset();
    rst_v = 1;
    run(3);
    n_tests++;
    if (rd_o !== '0 || out_we_o !== 1'b0 || busy_o !== 1'b0 || out_chn_o !== '0 ||
        out_first_o !== 1'b0 || out_last_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got rd=%b we=%0b busy=%0b chn=%0d f=%0b l=%0b exp all zero",
               rd_o, out_we_o, busy_o, out_chn_o, out_first_o, out_last_o);
    end
  endtask

  task automatic test_single_burst();
    clear_logs();
    rst_v = 0; en_v = 1; bl_v = 4; dr_v = 1; cnt[2] = 10;
    wait_grants(1, 20, "single");
    en_v = 0;
    wait_bursts(1, 20, "single");
    step();
    n_tests++;
    if (qget(grant_log, 0) != 2 || qget(words_log, 0) != 4 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_burst got chn=%0d words=%0d busy=%0b exp chn=2 words=4 busy=0",
               qget(grant_log, 0), qget(words_log, 0), busy_o);
    end
    quiesce();
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    clear_logs();
    autofill = '1; en_v = 1; bl_v = 4; dr_v = 1;
    wait_grants(5, 60, "b2b");
    run(2);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (qget(grant_log, i) != (i % NCH)) begin
        n_fail++;
        $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, qget(grant_log, i), i % NCH);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (qget(gap_log, i) != 3) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d] got=%0d exp=3 cycles last-to-first", i, qget(gap_log, i));
      end
    end
    quiesce();
  endtask

  task automatic test_flush_partial();
    clear_logs();
    cnt[1] = 2; bl_v = 4; flush_v = 0; en_v = 1; dr_v = 1;
    run(8);
    n_tests++;
    if (grant_log.size() != 0) begin
      n_fail++;
      $display("FAIL noflush_grant got=%0d grants exp=0", grant_log.size());
    end
    flush_v = 1;
    wait_bursts(1, 40, "flush");
    n_tests++;
    if (qget(grant_log, 0) != 1 || qget(words_log, 0) != 2) begin
      n_fail++;
      $display("FAIL flush_partial got chn=%0d words=%0d exp chn=1 words=2",
               qget(grant_log, 0), qget(words_log, 0));
    end
    quiesce();
  endtask

  task automatic test_max_burst_stalls();
    clear_logs();
    cnt[3] = 40; bl_v = 0; en_v = 1; dr_rand = 1;
    wait_grants(1, 30, "max");
    en_v = 0;
    wait_words(5, 200);
    nblk[3] = 1;
    run(3);
    nblk = '0;
    wait_bursts(1, 300, "max");
    n_tests++;
    if (qget(grant_log, 0) != 3 || qget(words_log, 0) != 16) begin
      n_fail++;
      $display("FAIL max_burst got chn=%0d words=%0d exp chn=3 words=16",
               qget(grant_log, 0), qget(words_log, 0));
    end
    quiesce();
  endtask

  task automatic test_single_word();
    clear_logs();
    cnt[0] = 1; hid[0] = 1; bl_v = 4; flush_v = 1; en_v = 1; dr_v = 1;
    wait_bursts(1, 40, "single_word");
    n_tests++;
    if (qget(words_log, 0) != 1 || fl_both != 1) begin
      n_fail++;
      $display("FAIL single_word got words=%0d first_and_last=%0d exp words=1 first_and_last=1",
               qget(words_log, 0), fl_both);
    end
    quiesce();
  endtask

  task automatic test_reset_midburst_and_en();
    pulse_reset();
    clear_logs();
    autofill[0] = 1; autofill[1] = 1; bl_v = 8; en_v = 1; dr_v = 1;
    wait_grants(1, 20, "rstmid");
    wait_words(3, 40);
    rst_v = 1;
    step();
    rst_v = 0;
    step();
    n_tests++;
    if (rd_o !== '0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_midburst got rd=%b busy=%0b exp rd=0 busy=0", rd_o, busy_o);
    end
    wait_grants(2, 20, "rstmid");
    en_v = 0;
    wait_bursts(1, 40, "rstmid");
    run(20);
    n_tests++;
    if (qget(grant_log, 0) != 0 || qget(grant_log, 1) != 0 || grant_log.size() != 2 ||
        qget(words_log, 0) != 8) begin
      n_fail++;
      $display("FAIL rst_restart_en got g0=%0d g1=%0d ngrants=%0d words=%0d exp g0=0 g1=0 ngrants=2 words=8",
               qget(grant_log, 0), qget(grant_log, 1), grant_log.size(), qget(words_log, 0));
    end
    quiesce();
  endtask

  task automatic test_random();
    pulse_reset();
    clear_logs();
    en_v = 1; dr_rand = 1; bl_v = 3;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0 && cnt[c] < 600) cnt[c] += $urandom_range(0, 5);
      if (i % 37 == 0) begin
        flush_v = 1'($urandom_range(0, 1));
        bl_v = $urandom_range(0, 15);
        en_v = ($urandom_range(0, 7) != 0);
      end
      step();
    end
    n_tests++;
    if (burst_cnt == 0) begin
      n_fail++;
      $display("FAIL random_activity got=0 bursts exp>0");
    end
    quiesce();
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      cnt[c] = 0; hid[c] = 0; p_fill[c] = 0; p_ne[c] = 0;
    end
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_flush_partial();
    test_max_burst_stalls();
    test_single_word();
    test_reset_midburst_and_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
